// File: rtl/cell_mem_seq_pkg.sv
// Shared types and geometry helpers for the cell-state store sequencer.
// Region bounds are derived from the FRT_CELL/MID_CELL geometry.
package cell_mem_pkg;

  typedef enum logic [1:0] {
    REG_FRONT = 2'd0,
    REG_MID   = 2'd1,
    REG_BACK  = 2'd2,
    REG_ALL   = 2'd3
  } region_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  typedef enum logic {
    GNT_ENG  = 1'b0,
    GNT_HOST = 1'b1
  } grant_e;

  localparam int DEF_FRT_CELL = 32;
  localparam int DEF_MID_CELL = 20;

  function automatic int calc_depth(int frt, int mid);
    return 2 * frt * mid + 2 * frt;
  endfunction

  function automatic int calc_addr_w(int frt, int mid);
    return $clog2(calc_depth(frt, mid));
  endfunction

  localparam int DEPTH  = calc_depth(DEF_FRT_CELL, DEF_MID_CELL);
  localparam int ADDR_W = calc_addr_w(DEF_FRT_CELL, DEF_MID_CELL);

  function automatic int region_base(region_e r, int frt, int mid);
    int b;
    b = 0;
    case (r)
      REG_MID:  b = 2 * frt;
      REG_BACK: b = 2 * frt + frt * mid;
      default:  b = 0;
    endcase
    return b;
  endfunction

  // Inclusive last address of a region.
  function automatic int region_last(region_e r, int frt, int mid);
    int l;
    l = calc_depth(frt, mid) - 1;
    case (r)
      REG_FRONT: l = 2 * frt - 1;
      REG_MID:   l = 2 * frt + frt * mid - 1;
      default:   l = calc_depth(frt, mid) - 1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/cell_mem_seq_if.sv
// Command, host-write and memory-write bundle for cell_mem_seq.
// The master side issues commands/host writes; the slave side is the sequencer.
interface cell_mem_seq_if
  import cell_mem_pkg::*;
#(
  parameter int ADDR_W = cell_mem_pkg::ADDR_W,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_bank;
  logic [1:0]        cmd_region;
  logic [DATA_W-1:0] cmd_fill;
  logic              hw_valid;
  logic              hw_ready;
  logic [1:0]        hw_bank;
  logic [ADDR_W-1:0] hw_addr;
  logic [DATA_W-1:0] hw_data;
  logic              mem_we;
  logic [1:0]        mem_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_bank, cmd_region, cmd_fill,
    output hw_valid, hw_bank, hw_addr, hw_data,
    input  cmd_ready, hw_ready, mem_we, mem_bank, mem_addr, mem_wdata,
    input  busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_bank, cmd_region, cmd_fill,
    input  hw_valid, hw_bank, hw_addr, hw_data,
    output cmd_ready, hw_ready, mem_we, mem_bank, mem_addr, mem_wdata,
    output busy, done, err
  );
endinterface

// File: rtl/cell_mem_seq_rr_arb2.sv
// Two-requester round-robin arbiter for the shared memory write port.
// The last-grant flag resets to engine so the host wins the first contention.
module rr_arb2
  import cell_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_eng_i,
  input  logic req_host_i,
  output logic gnt_eng_o,
  output logic gnt_host_o
);
  grant_e last_q, last_d;

  always_comb begin
    gnt_host_o = req_host_i && (!req_eng_i || last_q == GNT_ENG);
    gnt_eng_o  = req_eng_i && !gnt_host_o;
    last_d     = last_q;
    if (gnt_host_o) begin
      last_d = GNT_HOST;
    end else if (gnt_eng_o) begin
      last_d = GNT_ENG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_ENG;
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/cell_mem_seq.sv
// Region-fill sequencer sharing one registered write port with host writes.
// A command arriving in the done cycle issues its first word at once, so fills chain without a gap.
module cell_mem_seq
  import cell_mem_pkg::*;
#(
  parameter int FRT_CELL = 32,
  parameter int MID_CELL = 20,
  parameter int DATA_W   = 16
) (
  input logic           clk,
  input logic           rst_n,
  cell_mem_seq_if.slave bus
);
  localparam int DEPTH_L = calc_depth(FRT_CELL, MID_CELL);
  localparam int AW      = calc_addr_w(FRT_CELL, MID_CELL);

  state_e            state_q, state_d;
  logic [1:0]        bank_q, bank_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     end_q, end_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_bank_q, mem_bank_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic          eng_req, eng_gnt, host_gnt;
  logic          cmd_legal, host_legal;
  logic [AW-1:0] cmd_base, cmd_last;

  assign cmd_legal  = (bus.cmd_bank != 2'd3);
  assign host_legal = (bus.hw_bank != 2'd3) && (int'(bus.hw_addr) < DEPTH_L);
  assign cmd_base   = AW'(region_base(region_e'(bus.cmd_region), FRT_CELL, MID_CELL));
  assign cmd_last   = AW'(region_last(region_e'(bus.cmd_region), FRT_CELL, MID_CELL));
  assign eng_req    = (state_q == ST_FILL) ||
                      (state_q == ST_IDLE && done_q && bus.cmd_valid && cmd_legal);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_eng_i  (eng_req),
    .req_host_i (bus.hw_valid),
    .gnt_eng_o  (eng_gnt),
    .gnt_host_o (host_gnt)
  );

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    fill_d      = fill_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    mem_we_d    = 1'b0;
    mem_bank_d  = mem_bank_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Illegal host writes are consumed but never reach the store.
    if (host_gnt) begin
      if (host_legal) begin
        mem_we_d    = 1'b1;
        mem_bank_d  = bus.hw_bank;
        mem_addr_d  = bus.hw_addr;
        mem_wdata_d = bus.hw_data;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (!cmd_legal) begin
            err_d = 1'b1;
          end else begin
            bank_d  = bus.cmd_bank;
            fill_d  = bus.cmd_fill;
            end_d   = cmd_last;
            ptr_d   = cmd_base;
            state_d = ST_FILL;
            if (eng_gnt) begin
              mem_we_d    = 1'b1;
              mem_bank_d  = bus.cmd_bank;
              mem_addr_d  = cmd_base;
              mem_wdata_d = bus.cmd_fill;
              if (cmd_base == cmd_last) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                ptr_d = cmd_base + 1'b1;
              end
            end
          end
        end
      end
      ST_FILL: begin
        if (eng_gnt) begin
          mem_we_d    = 1'b1;
          mem_bank_d  = bank_q;
          mem_addr_d  = ptr_q;
          mem_wdata_d = fill_q;
          if (ptr_q == end_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      fill_q      <= '0;
      ptr_q       <= '0;
      end_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_bank_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      fill_q      <= fill_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
      mem_we_q    <= mem_we_d;
      mem_bank_q  <= mem_bank_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.hw_ready  = host_gnt;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_bank  = mem_bank_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
